// File: rtl/cmd_framer.sv
// UART byte stream to 24-bit command framer with a first-word-fall-through command FIFO.
// Optional inter-byte timeout is enabled by defining CMD_FRAMER_TIMEOUT_EN.
module cmd_framer #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 4340
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [3*DATA_WIDTH-1:0]       m_cmd_tdata,
    output logic                          m_cmd_tvalid,
    input  logic                          m_cmd_tready,
    output logic                          frame_err,
    output logic                          drop_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CMD_W = 3 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GOT1 = 2'd1,
        GOT2 = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   b0_q, b0_d;
    logic [DATA_WIDTH-1:0]   b1_q, b1_d;
    logic                    rdy_q;
    logic                    ferr_q, ferr_d;
    logic                    drop_q, drop_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic [CMD_W-1:0]        mem_q [FIFO_DEPTH];

    logic                    hs;
    logic                    start_bit;
    logic                    push;
    logic [CMD_W-1:0]        push_word;
    logic                    empty;
    logic                    full;
    logic                    pop;
    logic                    wr_en;
    logic                    tmo_hit;

    assign hs        = s_axis_tvalid & rdy_q;
    assign start_bit = s_axis_tdata[DATA_WIDTH-1];
    assign push_word = {b0_q, b1_q, s_axis_tdata};

`ifdef CMD_FRAMER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counter only runs while a partial frame is held; any accepted byte restarts it.
    assign tmo_hit = (state_q != IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q + TMO_W'(1);
        if (hs || (state_q == IDLE) || tmo_hit) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    // A start byte arriving mid-frame restarts the frame instead of being thrown away.
    always_comb begin
        state_d = state_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
        if (hs) begin
            case (state_q)
                IDLE: begin
                    if (start_bit) begin
                        b0_d    = s_axis_tdata;
                        state_d = GOT1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
                GOT1: begin
                    if (!start_bit) begin
                        b1_d    = s_axis_tdata;
                        state_d = GOT2;
                    end else begin
                        ferr_d  = 1'b1;
                        b0_d    = s_axis_tdata;
                    end
                end
                GOT2: begin
                    if (!start_bit) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        b0_d    = s_axis_tdata;
                        state_d = GOT1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (tmo_hit) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == LVL_W'(FIFO_DEPTH));
        pop      = !empty && m_cmd_tready;
        wr_en    = push && (!full || pop);
        drop_d   = push && full && !pop;
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            b0_q     <= '0;
            b1_q     <= '0;
            rdy_q    <= 1'b0;
            ferr_q   <= 1'b0;
            drop_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            b0_q     <= b0_d;
            b1_q     <= b1_d;
            rdy_q    <= 1'b1;
            ferr_q   <= ferr_d;
            drop_q   <= drop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign s_axis_tready = rdy_q;
    assign m_cmd_tvalid  = !empty;
    assign m_cmd_tdata   = empty ? '0 : mem_q[rd_ptr_q];
    assign frame_err     = ferr_q;
    assign drop_err      = drop_q;
    assign fifo_level    = level_q;

endmodule

// File: tb/tb_cmd_framer.sv
// Scoreboard bench for cmd_framer: a byte-level frame model feeds an expected-word queue that a
// negedge monitor drains whenever the DUT hands a word to the decoder.
module tb_cmd_framer;

    localparam int DEPTH = 8;
    localparam int TMO   = 4340;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [23:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        frame_err;
    logic        drop_err;
    logic [3:0]  fifo_level;

    int errors = 0;
    int checks = 0;
    int exp_ferr = 0;
    int exp_drop = 0;
    int mon_ferr = 0;
    int mon_drop = 0;
    int rdy_mode = 0;
    logic [23:0] sb[$];
    logic [7:0]  part[$];

    cmd_framer #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_cmd_tdata   (m_tdata),
        .m_cmd_tvalid  (m_tvalid),
        .m_cmd_tready  (m_tready),
        .frame_err     (frame_err),
        .drop_err      (drop_err),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a frame is one start byte then two payload bytes.
    function automatic void model_push(input logic [23:0] w);
        if (sb.size() >= DEPTH) exp_drop++;
        else sb.push_back(w);
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b[7]) begin
            if (part.size() != 0) exp_ferr++;
            part.delete();
            part.push_back(b);
        end else if (part.size() == 0) begin
            exp_ferr++;
        end else begin
            part.push_back(b);
            if (part.size() == 3) begin
                model_push({part[0], part[1], part[2]});
                part.delete();
            end
        end
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = ($urandom_range(3) != 0);
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            if (frame_err) mon_ferr++;
            if (drop_err) mon_drop++;
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_unexpected: got 0x%0h expected no word", m_tdata);
                end else begin
                    chk("word", {8'h00, m_tdata}, {8'h00, sb.pop_front()});
                end
            end
        end
    end

    // Caller is aligned 1 time unit after a rising edge; returns aligned the same way.
    task automatic send_byte(input logic [7:0] b);
        s_tvalid = 1'b1;
        s_tdata  = b;
        @(negedge clk);
        #2;
        model_byte(b);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] w);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic drain(input string name);
        int n;
        rdy_mode = 1;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk($sformatf("%s_drain_left", name), sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_errs(input string name);
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("%s_frame_err_count", name), mon_ferr, exp_ferr);
        chk($sformatf("%s_drop_err_count", name), mon_drop, exp_drop);
    endtask

    task automatic set_mode(input int m);
        rdy_mode = m;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int f0;
        int d0;
        logic [23:0] w;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", s_tready, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_drop_err", drop_err, 0);
        chk("rst_level", fifo_level, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("tready_before_edge", s_tready, 0);
        @(negedge clk);
        chk("tready_after_edge", s_tready, 1);
        @(posedge clk);
        #1;

        // T1: basic frame and push latency
        set_mode(1);
        f0 = mon_ferr;
        send_byte(8'h81);
        send_byte(8'h25);
        send_byte(8'h7F);
        @(negedge clk);
        chk("t1_latency_tvalid", m_tvalid, 1);
        chk("t1_latency_tdata", m_tdata, 24'h81257F);
        @(posedge clk);
        #1;
        drain("t1");
        check_errs("t1");
        chk("t1_no_frame_err", mon_ferr - f0, 0);

        // T2: start byte in payload slot restarts the frame
        f0 = mon_ferr;
        send_byte(8'h81); send_byte(8'h25); send_byte(8'hA0); send_byte(8'h10); send_byte(8'h33);
        drain("t2");
        check_errs("t2");
        chk("t2_one_frame_err", mon_ferr - f0, 1);

        // T3: stray payload byte in IDLE
        f0 = mon_ferr;
        send_byte(8'h12);
        send_frame(24'h810001);
        drain("t3");
        check_errs("t3");
        chk("t3_one_frame_err", mon_ferr - f0, 1);

        // T4: fill the FIFO with the decoder stalled, ninth frame dropped
        set_mode(0);
        d0 = mon_drop;
        for (int i = 1; i <= 9; i++) send_frame({8'h80 | 8'(i), 8'(i), 8'(i * 3)});
        @(negedge clk);
        chk("t4_level_full", fifo_level, 8);
        @(posedge clk);
        #1;
        check_errs("t4");
        chk("t4_one_drop", mon_drop - d0, 1);
        drain("t4");
        @(negedge clk);
        chk("t4_level_empty", fifo_level, 0);
        @(posedge clk);
        #1;

        // T5: push and pop together while full
        set_mode(0);
        d0 = mon_drop;
        for (int i = 1; i <= 8; i++) send_frame({8'hC0 | 8'(i), 8'(i), 8'h55});
        send_byte(8'hEE);
        send_byte(8'h11);
        @(negedge clk);
        rdy_mode = 1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b1;
        s_tdata  = 8'h22;
        @(negedge clk);
        rdy_mode = 0;
        #2;
        model_byte(8'h22);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        chk("t5_level_stays_full", fifo_level, 8);
        @(posedge clk);
        #1;
        check_errs("t5");
        chk("t5_no_drop", mon_drop - d0, 0);
        drain("t5");

        // T6: reset mid-frame discards the partial frame
        send_byte(8'h81);
        send_byte(8'h25);
        @(negedge clk);
        rst = 1'b0;
        part.delete();
        sb.delete();
        @(negedge clk);
        chk("t6_rst_level", fifo_level, 0);
        chk("t6_rst_tready", s_tready, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        f0 = mon_ferr;
        send_byte(8'h42);
        check_errs("t6");
        chk("t6_one_frame_err", mon_ferr - f0, 1);
        chk("t6_no_word", m_tvalid, 0);

        // Random traffic with a random decoder stall pattern, kept clear of overflow
        set_mode(2);
        for (int i = 0; i < 120; i++) begin
            n = ($urandom_range(9) < 8) ? 3 : 1;
            w = {1'b1, 7'($urandom), 1'b0, 7'($urandom), 1'b0, 7'($urandom)};
            if (n == 1) w[23:16] = 8'($urandom);
            for (int k = 0; k < n; k++) begin
                int waitc;
                waitc = 0;
                while (sb.size() >= 6 && waitc < 200) begin
                    @(posedge clk);
                    #1;
                    waitc++;
                end
                if (waitc >= 200) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_backlog: got %0d words pending expected below 6", sb.size());
                end
                repeat ($urandom_range(2)) begin
                    @(posedge clk);
                    #1;
                end
                send_byte(w[23 - 8 * k -: 8]);
            end
        end
        drain("rand");
        check_errs("rand");

        // T7: long gap inside a frame
        f0 = mon_ferr;
        send_byte(8'h81);
        send_byte(8'h25);
        repeat (TMO + 20) @(posedge clk);
        #1;
`ifdef CMD_FRAMER_TIMEOUT_EN
        if (part.size() != 0) exp_ferr++;
        part.delete();
`endif
        send_byte(8'h42);
        drain("t7");
        check_errs("t7");
`ifdef CMD_FRAMER_TIMEOUT_EN
        chk("t7_frame_err_pulses", mon_ferr - f0, 2);
`else
        chk("t7_frame_err_pulses", mon_ferr - f0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
